// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB completer register file.
package apb_pkg;
    typedef enum logic [0:0] {IDLE, ACCESS} apb_slv_state_t;
    localparam int DEFAULT_NUM_REGS = 16;
    localparam logic [31:0] ID_REG_OFFSET = 32'((DEFAULT_NUM_REGS - 1) * 4);
    localparam int ERR_ALIGN = 0;
    localparam int ERR_RANGE = 1;
    localparam int ERR_PROT  = 2;
    localparam int ERR_NSE   = 3;
    localparam int ERR_RO    = 4;
    localparam int ERR_W     = 5;
endpackage

// File: rtl/apb_strb_reg.sv
// apb_strb_reg: 32-bit register with byte-lane write strobes.
module apb_strb_reg
    import apb_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        we,
    input  logic [3:0]  strb,
    input  logic [31:0] d,
    output logic [31:0] q
);
    always_ff @(posedge PCLK or posedge PRESET)
        if (PRESET)
            q <= '0;
        else if (we)
            for (int b = 0; b < 4; b++)
                if (strb[b]) q[8*b +: 8] <= d[8*b +: 8];
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with wait states, byte strobes, error response
// and a flat export of a small register file whose top word is a read-only ID.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter int          PROT_CHECK  = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         PSELx,
    input  logic                         PENABLE,
    input  logic [ADDR_WIDTH-1:0]        PADDR,
    input  logic                         PWRITE,
    input  logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic [DATA_WIDTH/8-1:0]      PSTRB,
    input  logic [2:0]                   PPROT,
    input  logic                         PNSE,
    output logic [DATA_WIDTH-1:0]        PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;

    apb_slv_state_t          state;
    logic [CW-1:0]           cnt;
    logic [IDX_W-1:0]        a_idx;
    logic                    a_write;
    logic [DATA_WIDTH-1:0]   a_wdata;
    logic [DATA_WIDTH/8-1:0] a_strb;
    logic                    err;
    logic [ERR_W-1:0]        err_v;
    logic                    done;
    logic                    we;
    logic                    unused_prot;

    assign unused_prot = ^PPROT[2:1];

    always_comb begin
        err_v = '0;
        err_v[ERR_ALIGN] = PADDR[1:0] != 2'b00;
        err_v[ERR_RANGE] = (PADDR >> (IDX_W + 2)) != '0 || int'(PADDR[IDX_W+1:2]) >= NUM_REGS;
        err_v[ERR_PROT]  = PROT_CHECK != 0 && !PPROT[0];
        err_v[ERR_NSE]   = PNSE;
        err_v[ERR_RO]    = PWRITE && int'(PADDR[IDX_W+1:2]) == NUM_REGS - 1;
    end

    // Dropping PSELx during the access phase is a master abort: nothing commits.
    always_ff @(posedge PCLK or posedge PRESET)
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            a_idx   <= '0;
            a_write <= 1'b0;
            a_wdata <= '0;
            a_strb  <= '0;
            err     <= 1'b0;
        end else if (state == IDLE) begin
            if (PSELx && !PENABLE) begin
                state   <= ACCESS;
                cnt     <= CW'(WAIT_CYCLES);
                a_idx   <= PADDR[IDX_W+1:2];
                a_write <= PWRITE;
                a_wdata <= PWDATA;
                a_strb  <= PSTRB;
                err     <= |err_v;
            end
        end else if (!PSELx || cnt == '0)
            state <= IDLE;
        else
            cnt <= cnt - 1'b1;

    assign done    = state == ACCESS && cnt == '0;
    assign we      = done && PSELx && a_write && !err;
    assign PREADY  = done;
    assign PSLVERR = done && err;
    assign PRDATA  = (done && !err) ? regs_flat[{a_idx, 5'd0} +: DATA_WIDTH] : '0;

    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_reg
        apb_strb_reg u_reg (
            .PCLK   (PCLK),
            .PRESET (PRESET),
            .we     (we && int'(a_idx) == i),
            .strb   (a_strb),
            .d      (a_wdata),
            .q      (regs_flat[32*i +: 32])
        );
    end

    assign regs_flat[32*(NUM_REGS-1) +: 32] = ID_VALUE;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: three completers (0, 2 and 3 wait states) driven by a
// transaction-level model; a negedge process compares every output every cycle.
module tb_apb_slave_regfile;
    import apb_pkg::*;
    localparam int N = 16;
    localparam logic [31:0] ID = 32'hA5B0_0001;
    typedef logic [N*32-1:0] wide_t;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic        PNSE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic [2:0]  PPROT = '0;
    logic        psel[3];
    logic        ready[3];
    logic        slverr[3];
    logic [31:0] rdata[3];
    wide_t       flat[3];

    logic        exp_ready[3];
    logic        exp_err[3];
    logic [31:0] exp_rd[3];
    logic [31:0] mreg[3][N];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 PCLK = ~PCLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_slave_regfile #(.WAIT_CYCLES(g == 0 ? 2 : g == 1 ? 0 : 3)) u_dut (
            .PCLK(PCLK), .PRESET(PRESET), .PSELx(psel[g]), .PENABLE(PENABLE),
            .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
            .PPROT(PPROT), .PNSE(PNSE), .PRDATA(rdata[g]), .PREADY(ready[g]),
            .PSLVERR(slverr[g]), .regs_flat(flat[g])
        );
    end

    function automatic int wc(input int k);
        return k == 0 ? 2 : k == 1 ? 0 : 3;
    endfunction

    function automatic logic model_err(input logic [31:0] a, input logic wr, input logic [2:0] p, input logic n);
        logic [ERR_W-1:0] c;
        c = '0;
        c[ERR_ALIGN] = a % 4 != 0;
        c[ERR_RANGE] = a >= N * 4;
        c[ERR_PROT]  = !p[0];
        c[ERR_NSE]   = n;
        c[ERR_RO]    = wr && (a >> 2) == N - 1;
        return |c;
    endfunction

    function automatic wide_t model_flat(input int k);
        wide_t f;
        for (int i = 0; i < N; i++) f[32*i +: 32] = mreg[k][i];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) mreg[k][i] = (i == N - 1) ? ID : '0;
            exp_ready[k] = 1'b0;
            exp_err[k] = 1'b0;
            exp_rd[k] = '0;
        end
    endtask

    task automatic chk(input string name, input int k, input wide_t got, input wide_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h expected %0h", name, k, got, exp);
        end
    endtask

    always @(negedge PCLK)
        for (int k = 0; k < 3; k++) begin
            chk("pready", k, wide_t'(ready[k]), wide_t'(exp_ready[k]));
            chk("pslverr", k, wide_t'(slverr[k]), wide_t'(exp_err[k]));
            chk("prdata", k, wide_t'(rdata[k]), wide_t'(exp_rd[k]));
            chk("regs_flat", k, flat[k], model_flat(k));
        end

    // Starts at posedge+1 with the setup phase and returns at posedge+1 after completion.
    task automatic xfer(input int k, input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic [2:0] prot, input logic nse,
                        input int abort_at, output logic [31:0] got_rd, output logic got_err);
        int w;
        int idx;
        logic e;
        w = wc(k);
        e = model_err(addr, wr, prot, nse);
        idx = int'(addr[5:2]);
        got_rd = '0;
        got_err = 1'b0;
        psel[k] = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr;
        PWDATA = wd; PSTRB = strb; PPROT = prot; PNSE = nse;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; PADDR = $urandom; PWDATA = $urandom;
        for (int j = 0; j <= w; j++) begin
            exp_ready[k] = j == w;
            exp_err[k] = j == w && e;
            exp_rd[k] = (j == w && !e) ? mreg[k][idx] : '0;
            if (j == w) begin
                got_rd = rdata[k];
                got_err = slverr[k];
            end
            if (j == abort_at) begin
                psel[k] = 1'b0;
                PENABLE = 1'b0;
            end
            @(posedge PCLK); #1;
            if (j == abort_at) break;
            if (j == w && wr && !e)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mreg[k][idx][8*b +: 8] = wd[8*b +: 8];
        end
        psel[k] = 1'b0; PENABLE = 1'b0;
        exp_ready[k] = 1'b0; exp_err[k] = 1'b0; exp_rd[k] = '0;
    endtask

    task automatic err_case(input logic [31:0] a, input logic wr, input logic [2:0] p, input logic n);
        logic [31:0] rd;
        logic er;
        xfer(0, a, wr, 32'hFFFF_FFFF, 4'hF, p, n, -1, rd, er);
        chk("err_pslverr", 0, wide_t'(er), wide_t'(1'b1));
        if (!wr) chk("err_prdata", 0, wide_t'(rd), '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic er;
        logic [31:0] a;
        logic [2:0] p;
        int k;
        int r;
        int ab;
        time t0;
        for (int i = 0; i < 3; i++) psel[i] = 1'b0;
        model_reset();
        @(posedge PCLK); #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_pready", i, wide_t'(ready[i]), '0);
            chk("rst_prdata", i, wide_t'(rdata[i]), '0);
            chk("rst_id", i, wide_t'(flat[i][32*(N-1) +: 32]), wide_t'(ID));
            chk("rst_regs", i, wide_t'(flat[i][32*(N-1)-1:0]), '0);
        end
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        t0 = $time;
        xfer(0, 32'h08, 1, 32'h1122_3344, 4'hF, 3'b001, 0, -1, rd, er);
        chk("w2_latency", 0, wide_t'($time - t0), wide_t'(40));
        chk("w2_write_err", 0, wide_t'(er), '0);
        chk("w2_reg2", 0, wide_t'(flat[0][95:64]), wide_t'(32'h1122_3344));
        xfer(0, 32'h08, 0, 32'h0, 4'h0, 3'b001, 0, -1, rd, er);
        chk("w2_read", 0, wide_t'(rd), wide_t'(32'h1122_3344));

        xfer(0, 32'h08, 1, 32'hAABB_CCDD, 4'b0101, 3'b001, 0, -1, rd, er);
        chk("strb_0101", 0, wide_t'(flat[0][95:64]), wide_t'(32'h11BB_33DD));
        xfer(0, 32'h08, 1, 32'hFFFF_FFFF, 4'b0000, 3'b001, 0, -1, rd, er);
        chk("strb_0000_err", 0, wide_t'(er), '0);
        chk("strb_0000", 0, wide_t'(flat[0][95:64]), wide_t'(32'h11BB_33DD));

        err_case(32'h09, 1, 3'b001, 0);
        err_case(32'h09, 0, 3'b001, 0);
        err_case(32'h40, 1, 3'b001, 0);
        err_case(32'h40, 0, 3'b001, 0);
        err_case(32'h08, 1, 3'b000, 0);
        err_case(32'h08, 0, 3'b000, 0);
        err_case(32'h08, 1, 3'b001, 1);
        err_case(32'h08, 0, 3'b001, 1);
        err_case(ID_REG_OFFSET, 1, 3'b001, 0);
        chk("err_no_change", 0, wide_t'(flat[0][95:64]), wide_t'(32'h11BB_33DD));

        xfer(0, ID_REG_OFFSET, 0, 32'h0, 4'h0, 3'b001, 0, -1, rd, er);
        chk("id_read", 0, wide_t'(rd), wide_t'(ID));
        chk("id_err", 0, wide_t'(er), '0);

        t0 = $time;
        xfer(1, 32'h14, 1, 32'hCAFE_F00D, 4'hF, 3'b001, 0, -1, rd, er);
        xfer(1, 32'h14, 0, 32'h0, 4'h0, 3'b001, 0, -1, rd, er);
        chk("w0_b2b_latency", 1, wide_t'($time - t0), wide_t'(40));
        chk("w0_read", 1, wide_t'(rd), wide_t'(32'hCAFE_F00D));

        xfer(2, 32'h10, 1, 32'h1234_5678, 4'hF, 3'b001, 0, 1, rd, er);
        chk("abort_no_write", 2, wide_t'(flat[2][159:128]), '0);

        psel[0] = 1'b1; PENABLE = 1'b1; PADDR = 32'h08; PWRITE = 1'b0;
        @(posedge PCLK); #1;
        psel[0] = 1'b0; PENABLE = 1'b0;
        chk("penable_in_idle", 0, wide_t'(ready[0]), '0);
        t0 = $time;
        xfer(0, 32'h08, 0, 32'h0, 4'h0, 3'b001, 0, -1, rd, er);
        chk("after_stray_latency", 0, wide_t'($time - t0), wide_t'(40));

        repeat (150) begin
            k = $urandom_range(2);
            r = $urandom_range(9);
            a = r < 7 ? 32'($urandom_range(N - 1)) << 2 : r == 7 ? 32'($urandom_range(63)) : 32'($urandom_range(255));
            p = 3'($urandom_range(7));
            if ($urandom_range(4) != 0) p[0] = 1'b1;
            ab = (wc(k) > 0 && $urandom_range(7) == 0) ? $urandom_range(wc(k) - 1) : -1;
            xfer(k, a, 1'($urandom_range(1)), $urandom, 4'($urandom_range(15)), p,
                 $urandom_range(15) == 0, ab, rd, er);
            if ($urandom_range(2) == 0) begin
                @(posedge PCLK); #1;
            end
        end

        psel[0] = 1'b1; PENABLE = 1'b0; PADDR = 32'h04; PWRITE = 1'b1;
        PWDATA = 32'hDEAD_BEEF; PSTRB = 4'hF; PPROT = 3'b001; PNSE = 1'b0;
        repeat (3) begin
            @(posedge PCLK); #1;
            PENABLE = 1'b1;
        end
        #2;
        PRESET = 1'b1;
        model_reset();
        #1;
        chk("midrst_pready", 0, wide_t'(ready[0]), '0);
        chk("midrst_pslverr", 0, wide_t'(slverr[0]), '0);
        chk("midrst_prdata", 0, wide_t'(rdata[0]), '0);
        psel[0] = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        chk("midrst_reg1", 0, wide_t'(flat[0][63:32]), '0);
        xfer(0, 32'h04, 1, 32'h0BAD_CAFE, 4'hF, 3'b001, 0, -1, rd, er);
        xfer(0, 32'h04, 0, 32'h0, 4'h0, 3'b001, 0, -1, rd, er);
        chk("postrst_read", 0, wide_t'(rd), wide_t'(32'h0BAD_CAFE));

        @(posedge PCLK); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
